// File: rtl/spi_frame_interceptor_pkg.sv
// Shared types and constants for the SPI frame interceptor.
// The optional hit counter is enabled with SPI_INTERCEPT_COUNT_EN (see spi_frame_interceptor.sv).
package spi_frame_interceptor_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] TRIGGER_CMD_DEF  = 8'h03;
    localparam logic [SPI_BYTE_W-1:0] REPLACE_BYTE_DEF = 8'hAA;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        CMD       = 3'd2,
        PASS      = 3'd3,
        INJECT    = 3'd4
    } state_e;

endpackage

// File: rtl/spi_frame_interceptor_edge.sv
// spi_edge_detect: registers a 1-bit signal and flags rising/falling edges
// in the cycle where the live value differs from the registered one.
module spi_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic prev_o,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign prev_o = prev_q;
    assign rise_o = sig_i & ~prev_q;
    assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/spi_frame_interceptor.sv
// Frame-aware SPI mode-0 interceptor: one-cycle registered passthrough, with MISO
// replaced by REPLACE_BYTE after a TRIGGER_CMD command. Macro SPI_INTERCEPT_COUNT_EN adds hit_count.
module spi_frame_interceptor
    import spi_frame_interceptor_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] TRIGGER_CMD  = TRIGGER_CMD_DEF,
    parameter logic [SPI_BYTE_W-1:0] REPLACE_BYTE = REPLACE_BYTE_DEF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       miso_in,
    input  logic       mosi_in,
    input  logic       sclk_in,
    input  logic       ss_in,
    output logic       miso_out,
    output logic       mosi_out,
    output logic       sclk_out,
    output logic       ss_out,
    output logic       active,
`ifdef SPI_INTERCEPT_COUNT_EN
    output logic [7:0] hit_count,
`endif
    output logic [2:0] state_o
);

    logic sclk_prev, sclk_rise, sclk_fall;
    logic ss_prev, ss_rise, ss_fall;

    state_e                  state_q, state_d;
    logic                    en_frame_q, en_frame_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [SPI_BYTE_W-1:0]   cmd_q, cmd_d;
    logic                    cmd_done_q, cmd_done_d;
    logic [SPI_BYTE_W-1:0]   rep_q, rep_d;
    logic                    bit_q, bit_d;
    logic                    miso_q, miso_d;
    logic                    mosi_q;

    // The edge detectors' history registers double as the SCLK/SS passthrough stage.
    spi_edge_detect #(.RESET_VAL(1'b0)) u_sclk_edge (
        .clk_i  (sys_clk),
        .rst_i  (rst),
        .sig_i  (sclk_in),
        .prev_o (sclk_prev),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_edge_detect #(.RESET_VAL(1'b1)) u_ss_edge (
        .clk_i  (sys_clk),
        .rst_i  (rst),
        .sig_i  (ss_in),
        .prev_o (ss_prev),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    always_comb begin
        state_d    = state_q;
        en_frame_d = en_frame_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        cmd_done_d = 1'b0;
        rep_d      = rep_q;
        // Outside INJECT the bit register follows MISO so entry never shows a stale bit.
        bit_d      = (state_q == INJECT) ? bit_q : miso_in;

        case (state_q)
            WAIT_IDLE: begin
                if (ss_in) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    state_d    = CMD;
                    en_frame_d = en;
                    cnt_d      = 3'd0;
                    cmd_d      = '0;
                    // A coincident SCLK rise is the first command bit.
                    if (sclk_rise) begin
                        cmd_d = {{(SPI_BYTE_W-1){1'b0}}, mosi_in};
                        cnt_d = 3'd1;
                    end
                end
            end
            CMD: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (cmd_done_q) begin
                    if (cmd_q == TRIGGER_CMD && en_frame_q) begin
                        state_d = INJECT;
                        rep_d   = REPLACE_BYTE;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = PASS;
                    end
                end else if (sclk_rise) begin
                    cmd_d = {cmd_q[SPI_BYTE_W-2:0], mosi_in};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cmd_done_d = 1'b1;
                    end
                end
            end
            PASS: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            INJECT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    bit_d = rep_q[SPI_BYTE_W-1];
                    cnt_d = cnt_q + 3'd1;
                    rep_d = (cnt_q == 3'd7) ? REPLACE_BYTE
                                            : {rep_q[SPI_BYTE_W-2:0], 1'b0};
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase

        miso_d = (state_q == INJECT) ? bit_q : miso_in;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_IDLE;
            en_frame_q <= 1'b0;
            cnt_q      <= 3'd0;
            cmd_q      <= '0;
            cmd_done_q <= 1'b0;
            rep_q      <= '0;
            bit_q      <= 1'b0;
            miso_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_frame_q <= en_frame_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            cmd_done_q <= cmd_done_d;
            rep_q      <= rep_d;
            bit_q      <= bit_d;
            miso_q     <= miso_d;
            mosi_q     <= mosi_in;
        end
    end

`ifdef SPI_INTERCEPT_COUNT_EN
    logic [7:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (state_q == CMD && state_d == INJECT && hit_q != 8'hFF) begin
            hit_d = hit_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hit_q <= 8'd0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_count = hit_q;
`endif

    assign miso_out = miso_q;
    assign mosi_out = mosi_q;
    assign sclk_out = sclk_prev;
    assign ss_out   = ss_prev;
    assign active   = (state_q == INJECT);
    assign state_o  = state_q;

endmodule
